i2c_arbiter: RTL
================

Name: i2c_arbiter

Overview:
Round-robin arbiter and sequencer that shares one I2C transaction engine (i2c_trans) between N_REQ requesters, e.g. the codec power-up configuration sequencer and a runtime volume/mute controller. It latches the winning requester's address, mode and register word, issues a single-tick start, and tracks engine busy/ready. It returns a completion acknowledge, or an error acknowledge on watchdog timeout. All sequencing advances on the shared I2C divider tick so the engine sees stable inputs.

Parameters:
N_REQ, 2, number of requesters (>=2)
TIMEOUT, 4095, max i_tick periods spent in WAIT_BUSY+WAIT_DONE before abort; counter width $clog2(TIMEOUT+1)

Ports:
i_clk  in  1  system clock (12 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_tick  in  1  one-i_clk-cycle enable from the I2C clock divider
i_req  in  N_REQ  per-requester request level
i_addr  in  7*N_REQ  per-requester 7-bit device address, requester k at [7k+6:7k]
i_mode  in  N_REQ  per-requester mode, 0=write 1=read
i_data  in  16*N_REQ  per-requester register word, requester k at [16k+15:16k]
o_gnt  out  N_REQ  one-hot grant, held from grant until ack
o_ack  out  N_REQ  one-hot, one i_clk cycle, transaction finished (normal or aborted)
o_err  out  1  one i_clk cycle, coincident with o_ack on timeout abort
o_busy  out  1  high in every state except IDLE
o_start  out  1  start to engine, high for exactly one tick period
o_addr  out  7  latched address to engine
o_mode  out  1  latched mode to engine
o_data  out  16  latched register word to engine
i_ready  in  1  engine ready: high when idle/complete, low while transferring

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_gnt, o_ack, o_err, o_busy, o_start = 0; o_addr/o_mode/o_data = 0; RR pointer = N_REQ-1, so requester 0 wins first; timeout counter = 0.
- Only state, pointer, latches and counter update on i_clk edges where i_tick=1; o_ack/o_err are combinational-free registered pulses on the same edge.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: on tick, if |i_req: winner = first requester set, searching from pointer+1 upward with wrap. Latch winner's addr/mode/data to o_addr/o_mode/o_data; set o_gnt one-hot; pointer <= winner; -> START. If no req: stay.
- START: o_start=1 for the whole tick period; next tick -> WAIT_BUSY; counter cleared.
- WAIT_BUSY: on tick, if i_ready=0 -> WAIT_DONE. Counter +1 each tick.
- WAIT_DONE: on tick, if i_ready=1 -> IDLE, pulse o_ack[winner], clear o_gnt. Counter +1 each tick.
- Timeout: if counter reaches TIMEOUT in WAIT_BUSY or WAIT_DONE, on that tick -> IDLE, pulse o_ack[winner] and o_err, clear o_gnt.
- Latency: req seen at tick T -> o_start high from T+1 to T+2 -> earliest ack at tick T+4 (engine drops ready within one tick).
- Latched outputs stay constant from grant until the next grant. A requester may change its data after grant without effect.
- A requester drops its req only after ack. A req dropped while granted does not abort: the transaction completes and ack is still pulsed. A req dropped before grant is simply not considered.
- Back-to-back: requester re-asserting or holding req is eligible on the tick after ack; RR guarantees another pending requester wins first.
- i_ready high throughout START is ignored (no premature done): completion requires observing ready low then high.
- Reset mid-transaction: immediate return to reset values; no ack issued.

Test Plan:
- Single requester: req[0]=1, addr=7'b0011010, mode=0, data=16'h1E00 -> o_gnt=01, o_start one tick with o_data=16'h1E00, engine model ready low 3 ticks -> o_ack=01 one cycle, o_err=0, o_busy falls.
- Contention: req=2'b11 held, data0=16'h0479, data1=16'h0679 -> grants alternate 01,10,01,10 and o_data alternates accordingly; no requester starves.
- Timeout: TIMEOUT=16, engine holds ready low forever -> 16 ticks after START, o_ack[winner]=1 with o_err=1, state IDLE, next request served normally.
- Stuck-ready engine: ready never drops, TIMEOUT=16 -> stays WAIT_BUSY, aborts with o_err after 16 ticks, no spurious normal ack.
- Req drop and data change after grant: requester 1 deasserts req and changes data to 16'hFFFF one tick after grant -> o_data unchanged, transaction completes, o_ack=10.
- Async reset asserted in WAIT_DONE -> all outputs 0 immediately; after release req[1] alone is granted, and with both requesting requester 0 wins first.

Source files
------------

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C transaction engine between requesters.
// All sequencing advances on the I2C divider tick; ack/err are one-cycle pulses.
module i2c_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tick,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [7*N_REQ-1:0]    i_addr,
    input  logic [N_REQ-1:0]      i_mode,
    input  logic [16*N_REQ-1:0]   i_data,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_ack,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_start,
    output logic [6:0]            o_addr,
    output logic                  o_mode,
    output logic [15:0]           o_data,
    input  logic                  i_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic [6:0]        addr_q, addr_d;
    logic              mode_q, mode_d;
    logic [15:0]       data_q, data_d;

    logic              found;
    logic [PW-1:0]     win;
    logic              expired;
    int                k;

    // Search from the requester after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        k     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!found && i_req[k]) begin
                found = 1'b1;
                win   = PW'(k);
            end
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        mode_d  = mode_q;
        data_d  = data_q;
        if (i_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        addr_d     = i_addr[7*win +: 7];
                        mode_d     = i_mode[win];
                        data_d     = i_data[16*win +: 16];
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        ptr_d      = win;
                        state_d    = START;
                    end
                end
                START: begin
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == WAIT_DONE && i_ready) begin
                        ack_d   = gnt_q;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end else if (expired) begin
                        ack_d   = gnt_q;
                        err_d   = 1'b1;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end else if (state_q == WAIT_BUSY && !i_ready) begin
                        state_d = WAIT_DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d  = (state_d != IDLE);
        start_d = (state_d == START);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(N_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            addr_q  <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_ack   = ack_q;
    assign o_err   = err_q;
    assign o_busy  = busy_q;
    assign o_start = start_q;
    assign o_addr  = addr_q;
    assign o_mode  = mode_q;
    assign o_data  = data_q;

endmodule
